// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared definitions for the PUF challenge controller:
//   - puf_state_e      : controller FSM states
//   - PUF_DEFAULT_TAPS : default Galois LFSR feedback mask (32-bit)
// -----------------------------------------------------------------------------
package puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DONE
    } puf_state_e;

    localparam logic [31:0] PUF_DEFAULT_TAPS = 32'h8020_0003;

endpackage

// File: rtl/puf_lfsr.sv
// -----------------------------------------------------------------------------
// puf_lfsr
// Galois LFSR that generates the challenge sequence.
// Ports:
//   clk, rst : clock, synchronous active-high reset (value returns to 0)
//   load     : load seed (a zero seed loads 1 so the register never locks up)
//   seed     : W-bit seed value
//   step     : advance one step: shift right, XOR TAPS if the bit shifted out is 1
//   value    : current LFSR state
// -----------------------------------------------------------------------------
module puf_lfsr
    import puf_pkg::*;
#(
    parameter int unsigned     W    = 32,
    parameter logic [W-1:0]    TAPS = W'(PUF_DEFAULT_TAPS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         step,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (seed == '0) ? W'(1) : seed;
        end else if (step) begin
            value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/puf_challenge_controller.sv
// -----------------------------------------------------------------------------
// puf_challenge_controller
// Drives a sequence of LFSR-generated challenges into a PUF, holds each one for
// SETTLE_CYCLES evaluation cycles, samples the response bit, and assembles
// RESP_W bits into resp_data delivered over a valid/ready handshake.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start, seed            : run request (accepted in IDLE only) and initial challenge
//   chal_out, puf_eval     : challenge to the PUF and its evaluate strobe
//   puf_resp               : PUF response bit, captured in SAMPLE
//   resp_data, resp_valid,
//   resp_ready             : collected response word and its handshake
//   busy                   : high in every state except IDLE
// Configuration:
//   PUF_MAJORITY_VOTE_EN   : when defined, each challenge is evaluated VOTES
//                            times and the stored bit is the majority result.
// -----------------------------------------------------------------------------
module puf_challenge_controller
    import puf_pkg::*;
#(
    parameter int unsigned          RESP_W        = 64,
    parameter int unsigned          CHAL_W        = 32,
    parameter logic [CHAL_W-1:0]    LFSR_TAPS     = CHAL_W'(PUF_DEFAULT_TAPS),
    parameter int unsigned          SETTLE_CYCLES = 4,
    parameter int unsigned          VOTES         = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAL_W-1:0] seed,
    output logic [CHAL_W-1:0] chal_out,
    output logic              puf_eval,
    input  logic              puf_resp,
    output logic [RESP_W-1:0] resp_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(RESP_W);
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

    puf_state_e        state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RESP_W-1:0] resp_data_q, resp_data_d;

    logic              lfsr_load;
    logic              lfsr_step;
    logic [CHAL_W-1:0] lfsr_value;

    logic              last_eval;
    logic              bit_val;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned VOTE_W = $clog2(VOTES + 1);

    logic [VOTE_W-1:0] vote_q, vote_d;
    logic [VOTE_W-1:0] ones_q, ones_d;
    logic [VOTE_W-1:0] ones_n;
`else
    // VOTES has no effect without majority voting: one evaluation per challenge.
    localparam int unsigned EVALS = (VOTES > 0) ? 1 : 1;
`endif

    puf_lfsr #(
        .W    (CHAL_W),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    // Result of the current SAMPLE cycle: whether this is the last evaluation
    // of the challenge and, if so, the bit to store.
    always_comb begin
`ifdef PUF_MAJORITY_VOTE_EN
        ones_n    = ones_q + VOTE_W'(puf_resp);
        last_eval = (vote_q == VOTE_W'(VOTES - 1));
        bit_val   = (ones_n > VOTE_W'(VOTES / 2));
`else
        last_eval = (EVALS == 1);
        bit_val   = puf_resp;
`endif
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        idx_d       = idx_q;
        resp_data_d = resp_data_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
        vote_d      = vote_q;
        ones_d      = ones_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lfsr_load   = 1'b1;
                    resp_data_d = '0;
                    idx_d       = '0;
                    settle_d    = '0;
`ifdef PUF_MAJORITY_VOTE_EN
                    vote_d      = '0;
                    ones_d      = '0;
`endif
                    state_d     = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (!last_eval) begin
`ifdef PUF_MAJORITY_VOTE_EN
                    // Same challenge again; the LFSR is not stepped between votes.
                    vote_d = vote_q + VOTE_W'(1);
                    ones_d = ones_n;
`endif
                    state_d = ST_APPLY;
                end else begin
`ifdef PUF_MAJORITY_VOTE_EN
                    vote_d = '0;
                    ones_d = '0;
`endif
                    resp_data_d[idx_q] = bit_val;
                    if (idx_q == IDX_W'(RESP_W - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        lfsr_step = 1'b1;
                        state_d   = ST_APPLY;
                    end
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            idx_q       <= '0;
            resp_data_q <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            vote_q      <= '0;
            ones_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            idx_q       <= idx_d;
            resp_data_q <= resp_data_d;
`ifdef PUF_MAJORITY_VOTE_EN
            vote_q      <= vote_d;
            ones_q      <= ones_d;
`endif
        end
    end

    assign chal_out   = lfsr_value;
    assign puf_eval   = (state_q == ST_APPLY);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_puf_challenge_controller.sv
// -----------------------------------------------------------------------------
// tb_puf_challenge_controller
// Self-checking bench for puf_challenge_controller (RESP_W=8, SETTLE_CYCLES=4).
// A PUF model drives puf_resp in one of four modes; expected words come from a
// software Galois LFSR plus per-evaluation response rules.
// Latency is counted as the rising edge (after the start-accept edge) at which
// a downstream flop first registers resp_valid high.
// -----------------------------------------------------------------------------
module tb_puf_challenge_controller;

    localparam int unsigned RESP_W = 8;
    localparam int unsigned CHAL_W = 32;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned VOTES  = 3;
    localparam logic [31:0] TAPS   = 32'h8020_0003;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int V_EFF = VOTES;
`else
    localparam int V_EFF = 1;
`endif
    localparam int EXP_LAT = RESP_W * V_EFF * (SETTLE + 1) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CHAL_W-1:0] seed;
    logic [CHAL_W-1:0] chal_out;
    logic              puf_eval;
    logic              puf_resp;
    logic [RESP_W-1:0] resp_data;
    logic              resp_valid;
    logic              resp_ready;
    logic              busy;

    puf_challenge_controller #(
        .RESP_W        (RESP_W),
        .CHAL_W        (CHAL_W),
        .LFSR_TAPS     (TAPS),
        .SETTLE_CYCLES (SETTLE),
        .VOTES         (VOTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .chal_out   (chal_out),
        .puf_eval   (puf_eval),
        .puf_resp   (puf_resp),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // PUF model: 0 = constant 1, 1 = chal_out[0], 2 = per-evaluation pattern,
    // 3 = parity of (chal_out & mask).
    int          mode;
    logic [31:0] mask;
    logic [2:0]  pat;
    int          ev_cnt;
    logic        prev_eval;

    always @(posedge clk) begin
        prev_eval <= puf_eval;
        if (start && !busy) ev_cnt <= 0;
        else if (prev_eval && !puf_eval) ev_cnt <= ev_cnt + 1;
    end

    always_comb begin
        case (mode)
            0:       puf_resp = 1'b1;
            1:       puf_resp = chal_out[0];
            2:       puf_resp = pat[ev_cnt % 3];
            default: puf_resp = ^(chal_out & mask);
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] galois(input logic [31:0] c);
        return c[0] ? ((c >> 1) ^ TAPS) : (c >> 1);
    endfunction

    function automatic int resp_of(input logic [31:0] c, input int md,
                                   input logic [31:0] mk, input logic [2:0] pt, input int e);
        case (md)
            0:       return 1;
            1:       return int'(c[0]);
            2:       return int'(pt[e % 3]);
            default: return int'(^(c & mk));
        endcase
    endfunction

    function automatic logic [7:0] model(input logic [31:0] sd, input int md,
                                        input logic [31:0] mk, input logic [2:0] pt);
        logic [31:0] c = (sd == 0) ? 32'd1 : sd;
        logic [7:0]  w = '0;
        int          e = 0;
        for (int i = 0; i < RESP_W; i++) begin
            int ones = 0;
            for (int k = 0; k < V_EFF; k++) begin
                ones += resp_of(c, md, mk, pt, e);
                e++;
            end
            w[i] = (ones * 2 > V_EFF);
            c = galois(c);
        end
        return w;
    endfunction

    typedef struct {
        logic [31:0] seed;
        int          mode;
        logic [31:0] mask;
        logic [2:0]  pat;
        int          ready_delay;
        logic [7:0]  exp_data;
    } vec_t;

    task automatic start_run(input vec_t v);
        mode = v.mode;
        mask = v.mask;
        pat  = v.pat;
        resp_ready = (v.ready_delay == 0);
        @(negedge clk);
        seed  = v.seed;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seed  = $urandom;
    endtask

    task automatic do_run(input string tag, input vec_t v, input bit partial_chk);
        int  n = 0;
        bit  got = 0;
        start_run(v);
        check({tag, "_busy"}, busy, 1);
        while (n < 3000) begin
            @(negedge clk);
            if (partial_chk && n == 3 * V_EFF * (SETTLE + 1))
                check({tag, "_partial"}, resp_data, 8'h07);
            if (resp_valid) begin
                got = 1;
                break;
            end
            @(posedge clk);
            n++;
        end
        if (!got) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        check({tag, "_latency"}, n + 1, EXP_LAT);
        check({tag, "_data"}, resp_data, v.exp_data);
        for (int k = 0; k < v.ready_delay; k++) begin
            if (k == 3 || k == 6) start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check({tag, "_hold_valid"}, resp_valid, 1);
            check({tag, "_hold_data"}, resp_data, v.exp_data);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_valid_drop"}, resp_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t rv;
        int   vcount;

        tbl[0] = '{32'h1234_5678, 0, 32'h0,         3'b000, 0,  8'hFF};
        tbl[1] = '{32'h0000_ACE1, 1, 32'h0,         3'b000, 2,  8'h00};
        tbl[2] = '{32'h0000_0000, 1, 32'h0,         3'b000, 0,  8'h00};
        tbl[3] = '{32'hDEAD_BEEF, 2, 32'h0,         3'b011, 1,  8'h00};
        tbl[4] = '{32'h0000_0005, 2, 32'h0,         3'b010, 0,  8'h00};
        tbl[5] = '{32'hFFFF_FFFF, 3, 32'h0F0F_00FF, 3'b000, 10, 8'h00};
        tbl[1].exp_data = model(32'h0000_ACE1, 1, 32'h0, 3'b000);
        tbl[2].exp_data = model(32'h0000_0001, 1, 32'h0, 3'b000);
        tbl[3].exp_data = (V_EFF == 3) ? 8'hFF : 8'hDB;
        tbl[4].exp_data = (V_EFF == 3) ? 8'h00 : 8'h92;
        tbl[5].exp_data = model(32'hFFFF_FFFF, 3, 32'h0F0F_00FF, 3'b000);

        mode = 0; mask = '0; pat = '0;
        seed = 32'hA5A5_A5A5;
        rst = 1'b1; start = 1'b1; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  busy, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_eval",  puf_eval, 0);
        check("rst_data",  resp_data, 0);
        check("rst_chal",  chal_out, 0);
        start = 1'b0;
        rst   = 1'b0;
        resp_ready = 1'b0;

        for (int i = 0; i < 6; i++)
            do_run($sformatf("vec%0d", i), tbl[i], tbl[i].mode == 0);

        // Abort a run during the third bit.
        start_run(tbl[0]);
        repeat (2 * V_EFF * (SETTLE + 1) + 2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        resp_ready = 1'b0;
        check("abort_busy",  busy, 0);
        check("abort_valid", resp_valid, 0);
        check("abort_eval",  puf_eval, 0);
        check("abort_data",  resp_data, 0);
        check("abort_chal",  chal_out, 0);
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (resp_valid || busy) vcount++;
        end
        check("abort_quiet", vcount, 0);
        do_run("after_abort", tbl[1], 1'b0);

        // Randomised runs against the reference model.
        for (int r = 0; r < 6; r++) begin
            rv.seed        = $urandom;
            rv.mode        = ($urandom_range(0, 1) == 0) ? 1 : 3;
            rv.mask        = $urandom;
            rv.pat         = 3'($urandom);
            rv.ready_delay = $urandom_range(0, 3);
            rv.exp_data    = model(rv.seed, rv.mode, rv.mask, rv.pat);
            do_run($sformatf("rand%0d", r), rv, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
